// File: rtl/port_host_pkg.sv
// Shared definitions for the host-side port driver: byte width and TX FSM state encodings.
package port_host_pkg;

  localparam int PORT_W = 8;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_SETUP  = 3'd1,
    PH_STROBE = 3'd2,
    PH_HOLD   = 3'd3,
    PH_GAP    = 3'd4
  } ph_state_e;

endpackage

// File: rtl/port_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on pop_data while not empty.
module port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/port_host.sv
// Host-side driver for the computer's byte port: queued bytes go out as timed write
// strobes with stable data, and every change on port_out is handed back to the host.
module port_host
  import port_host_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 10,
  parameter int GAP_LEN   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [PORT_W-1:0] push_data,
  output logic              push_ready,
  output logic              port_write,
  output logic [PORT_W-1:0] port_in,
  input  logic [PORT_W-1:0] port_out,
  output logic              rx_valid,
  output logic [PORT_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              busy,
  output logic [2:0]        fsm_state
);

  // Handshakes: push moves a byte when push_valid && push_ready on a clock edge;
  // rx_data is consumed when rx_valid && rx_ready on a clock edge.

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  ph_state_e         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              write_n;
  logic              pop;
  logic              push_fire;
  logic [PORT_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_n;
  logic [PORT_W-1:0] last_out;

  port_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PORT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_ready = !fifo_full;
  assign push_fire  = push_valid && !fifo_full;
  assign fsm_state  = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    write_n = 1'b0;
    pop     = 1'b0;
    case (state)
      PH_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = PH_SETUP;
        end
      end
      PH_SETUP: begin
        state_n = PH_STROBE;
        cnt_n   = PULSE_LOAD;
        write_n = 1'b1;
      end
      PH_STROBE: begin
        if (cnt == '0) begin
          state_n = PH_HOLD;
        end else begin
          cnt_n   = cnt - CNT_W'(1);
          write_n = 1'b1;
        end
      end
      PH_HOLD: begin
        if (GAP_LEN == 0) begin
          state_n = PH_IDLE;
        end else begin
          state_n = PH_GAP;
          cnt_n   = GAP_LOAD;
        end
      end
      PH_GAP: begin
        if (cnt == '0) state_n = PH_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = PH_IDLE;
    endcase
  end

  // busy is registered, so it looks at the FIFO occupancy this edge produces.
  always_comb begin
    count_n = fifo_count + CW'(push_fire) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PH_IDLE;
      cnt        <= '0;
      port_write <= 1'b0;
      port_in    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      port_write <= write_n;
      if (pop) port_in <= fifo_head;
      busy       <= (count_n != '0) || (state_n != PH_IDLE);
    end
  end

  // A newer capture replaces an unconsumed one and flags the loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_out <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      overrun  <= 1'b0;
    end else if (port_out != last_out) begin
      last_out <= port_out;
      rx_data  <= port_out;
      rx_valid <= 1'b1;
      if (rx_valid && !rx_ready) overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_port_host.sv
// Bench for port_host: schedule-based reference model, per-cycle compare, strobe scoreboard.
module tb_port_host;
  import port_host_pkg::*;

  localparam int DEPTH     = 4;
  localparam int PULSE_LEN = 10;
  localparam int GAP_LEN   = 4;
  localparam int PERIOD    = PULSE_LEN + GAP_LEN + 3;

  logic       clk;
  logic       reset;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic       port_write;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       overrun;
  logic       busy;
  logic [2:0] fsm_state;

  port_host #(
    .DEPTH     (DEPTH),
    .PULSE_LEN (PULSE_LEN),
    .GAP_LEN   (GAP_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .port_write (port_write),
    .port_in    (port_in),
    .port_out   (port_out),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .overrun    (overrun),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // ph counts edges since the byte was popped; 0 means waiting for a byte.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         ph = 0;
  logic [7:0] m_port_in = 0;
  logic [7:0] m_last = 0;
  logic       m_rxv = 0;
  logic [7:0] m_rxd = 0;
  logic       m_ovr = 0;
  bit         model_ok = 0;

  always @(posedge clk) begin : model
    int sz;
    bit do_pop;
    bit do_push;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      ph = 0;
      m_port_in = 0;
      m_last = 0;
      m_rxv = 0;
      m_rxd = 0;
      m_ovr = 0;
      model_ok = 1;
    end else begin
      sz = mq.size();
      do_pop = (ph == 0) && (sz > 0);
      do_push = push_valid && (sz < DEPTH);
      if (do_pop) begin
        m_port_in = mq.pop_front();
        ph = 1;
      end else if (ph > 0) begin
        ph++;
        if (ph == PERIOD) ph = 0;
      end
      if (do_push) begin
        mq.push_back(push_data);
        exp_q.push_back(push_data);
      end
      if (port_out != m_last) begin
        if (m_rxv && !rx_ready) m_ovr = 1;
        m_last = port_out;
        m_rxd = port_out;
        m_rxv = 1;
      end else if (m_rxv && rx_ready) begin
        m_rxv = 0;
      end
    end
  end

  // ---------------- compare + scoreboard ----------------
  int   rise_q[$];
  logic prev_write = 0;

  always @(negedge clk) begin
    if (model_ok) begin
      check("port_write", port_write, (ph >= 2 && ph <= PULSE_LEN + 1));
      check("port_in", port_in, m_port_in);
      check("busy", busy, (mq.size() > 0) || (ph != 0));
      check("push_ready", push_ready, mq.size() < DEPTH);
      check("rx_valid", rx_valid, m_rxv);
      check("rx_data", rx_data, m_rxd);
      check("overrun", overrun, m_ovr);
      check("fsm_idle", fsm_state == PH_IDLE, ph == 0);
      if (port_write && !prev_write) begin
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
        else check("strobe_byte", port_in, exp_q.pop_front());
      end
      prev_write = port_write;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b, output int acc);
    int guard = 0;
    push_valid = 1'b1;
    push_data = b;
    while (!push_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("push_timeout", 1, 0);
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("idle_timeout", guard >= 300, 0);
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  initial begin
    #50000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_run();
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int acc[6];
    int first_hi;
    int hi_cnt;
    int base;

    reset = 1'b1;
    push_valid = 1'b0;
    push_data = 8'd0;
    port_out = 8'd0;
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_push_ready", push_ready, 1);
    check("rst_port_write", port_write, 0);
    check("rst_port_in", port_in, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    check("no_capture_const0", rx_valid, 0);

    // Single byte timing relative to the accepting edge E0.
    push_byte(8'd10, acc[0]);
    push_valid = 1'b0;
    check("single_busy_e0", busy, 1);
    first_hi = -1;
    hi_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) check("single_port_in_e1", port_in, 10);
      if (k == 1) check("single_write_e1", port_write, 0);
      if (port_write) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = k;
      end
      if (k == 12) check("single_write_fall_e12", port_write, 0);
      if (k == 16) check("single_busy_e16", busy, 1);
      if (k == 17) check("single_busy_e17", busy, 0);
    end
    check("single_first_high", first_hi, 2);
    check("single_high_cycles", hi_cnt, PULSE_LEN);
    check("single_port_in_kept", port_in, 10);

    // Back-to-back bytes: strobes one period apart.
    wait_idle();
    base = rise_q.size();
    push_byte(8'd10, acc[0]);
    push_byte(8'd5, acc[1]);
    push_byte(8'd3, acc[2]);
    push_valid = 1'b0;
    wait_idle();
    check("b2b_strobes", rise_q.size() - base, 3);
    if (rise_q.size() - base == 3) begin
      check("b2b_gap1", rise_q[base+1] - rise_q[base], 17);
      check("b2b_gap2", rise_q[base+2] - rise_q[base+1], 17);
    end
    check("b2b_port_in_last", port_in, 3);

    // Full FIFO: byte 6 waits through the full cycle that pops at E18.
    base = rise_q.size();
    for (int i = 0; i < 6; i++) push_byte(8'(i + 1), acc[i]);
    push_valid = 1'b0;
    check("full_accept_e4", acc[4] - acc[0], 4);
    check("full_accept_byte6", acc[5] - acc[0], 19);
    wait_idle();
    check("full_strobes", rise_q.size() - base, 6);
    check("full_scoreboard_empty", exp_q.size(), 0);
    check("full_port_in_last", port_in, 6);

    // RX handshake.
    port_out = 8'd55;
    @(negedge clk);
    check("rx_valid_55", rx_valid, 1);
    check("rx_data_55", rx_data, 55);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_consumed", rx_valid, 0);
    check("rx_no_overrun", overrun, 0);

    // Overrun on two unconsumed changes; sticky until reset.
    port_out = 8'd15;
    @(negedge clk);
    check("ovr_first_change", overrun, 0);
    port_out = 8'd7;
    @(negedge clk);
    check("ovr_data_7", rx_data, 7);
    check("ovr_set", overrun, 1);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    check("ovr_sticky", overrun, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("ovr_cleared", overrun, 0);
    @(negedge clk);
    check("rx_recapture_after_reset", rx_data, 7);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    port_out = 8'd9;
    @(negedge clk);
    port_out = 8'd4;
    rx_ready = 1'b1;
    @(negedge clk);
    check("chg_with_ready_data", rx_data, 4);
    check("chg_with_ready_valid", rx_valid, 1);
    check("chg_with_ready_ovr", overrun, 0);
    @(negedge clk);
    rx_ready = 1'b0;
    check("chg_with_ready_drain", rx_valid, 0);
    port_out = 8'd9;
    @(negedge clk);
    check("revisit_value_valid", rx_valid, 1);
    check("revisit_value_data", rx_data, 9);

    // Reset in the 5th STROBE cycle with two bytes still queued.
    wait_idle();
    push_byte(8'd7, acc[0]);
    push_byte(8'd8, acc[1]);
    push_byte(8'd9, acc[2]);
    push_valid = 1'b0;
    while (cyc < acc[0] + 6) @(negedge clk);
    check("mid_strobe_high", port_write, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_write", port_write, 0);
    check("mid_rst_port_in", port_in, 0);
    check("mid_rst_busy", busy, 0);
    hi_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (port_write) hi_cnt++;
    end
    check("mid_rst_no_strobes", hi_cnt, 0);

    finish_run();
  end

endmodule
